// File: rtl/trace_nibble_framer_if.sv
`default_nettype none
// ============================================================================
//  Module      : trace_nibble_framer_if
//  Description : Bundle between the 4-bit trace pins and the nibble framer.
//                Carries the raw trace nibble and capture enable in, and the
//                framed byte stream plus sync status out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface trace_nibble_framer_if;

  logic [3:0] trace_data;
  logic       capture_en;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       frame_start;
  logic       synced;
  logic       sync_err;
  logic [7:0] sync_err_count;

  // Trace side: drives the pins and enable, observes the framed stream.
  modport master (
    output trace_data,
    output capture_en,
    input  byte_out,
    input  byte_valid,
    input  frame_start,
    input  synced,
    input  sync_err,
    input  sync_err_count
  );

  // Framer side: samples the pins and produces the framed stream.
  modport slave (
    input  trace_data,
    input  capture_en,
    output byte_out,
    output byte_valid,
    output frame_start,
    output synced,
    output sync_err,
    output sync_err_count
  );

endinterface
`default_nettype wire

// File: rtl/trace_nibble_framer.sv
`default_nettype none
// ============================================================================
//  Module      : trace_nibble_framer
//  Description : Trace-port capture front end. Hunts for the TPIU full-sync
//                pattern on the 4-bit trace port, locks nibble/byte phase,
//                assembles bytes, strips full-sync packets and emits a byte
//                stream with frame-start markers.
//  Revision    : 1.0 - initial release
// ============================================================================
module trace_nibble_framer #(
  parameter int pFRAME_BYTES = 16
) (
  input  logic                 target_clk,
  input  logic                 reset,
  trace_nibble_framer_if.slave bus
);

  // Frame index width; a single-byte frame still needs a 1-bit counter.
  localparam int               IDX_W      = (pFRAME_BYTES > 1) ? $clog2(pFRAME_BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(pFRAME_BYTES - 1);
  localparam logic [31:0]      FULL_SYNC  = 32'h7FFF_FFFF;
  localparam int               PIPE_DEPTH = 4;

  typedef enum logic [0:0] {
    ST_HUNT   = 1'b0,
    ST_SYNCED = 1'b1
  } state_t;

  // Input sample and nibble history. Only history bits [31:4] are ever
  // compared (the current sample supplies the newest nibble), so the oldest
  // nibble of the 32-bit window is not stored.
  logic [3:0]  nib_q;
  logic [31:4] sr_q;
  logic        sync_match;

  // Framing state.
  state_t      state_q, state_d;
  logic        phase_q, phase_d;       // 1: nib_q holds a high nibble
  logic [3:0]  low_q, low_d;           // low nibble awaiting its partner

  // Four-deep byte pipeline. Deep enough to hold the first three bytes of a
  // full sync so they can be squashed once the closing 7F identifies it.
  logic [PIPE_DEPTH-1:0][7:0] pipe_data_q, pipe_data_d;
  logic [PIPE_DEPTH-1:0]      pipe_vld_q,  pipe_vld_d;

  // Output side.
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       byte_out_q, byte_out_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             sync_err_q, sync_err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  // Sample the trace pins every cycle and shift the nibble history.
  always_ff @(posedge target_clk or negedge reset) begin
    if (!reset) begin
      nib_q <= '0;
      sr_q  <= '0;
    end else begin
      nib_q <= bus.trace_data;
      sr_q  <= {nib_q, sr_q[31:8]};
    end
  end

  // Newest nibble on top: F,F,F,F,F,F,F,7 in arrival order.
  assign sync_match = ({nib_q, sr_q[31:4]} == FULL_SYNC);

  // Framing state and pipeline registers.
  always_ff @(posedge target_clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_HUNT;
      phase_q       <= 1'b0;
      low_q         <= '0;
      pipe_data_q   <= '0;
      pipe_vld_q    <= '0;
      idx_q         <= '0;
      byte_out_q    <= '0;
      byte_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      low_q         <= low_d;
      pipe_data_q   <= pipe_data_d;
      pipe_vld_q    <= pipe_vld_d;
      idx_q         <= idx_d;
      byte_out_q    <= byte_out_d;
      byte_valid_q  <= byte_valid_d;
      frame_start_q <= frame_start_d;
      sync_err_q    <= sync_err_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  // Next-state: sync hunting, byte assembly, sync stripping and emission.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    low_d         = low_q;
    pipe_data_d   = pipe_data_q;
    pipe_vld_d    = pipe_vld_q;
    idx_d         = idx_q;
    byte_out_d    = byte_out_q;
    byte_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    sync_err_d    = 1'b0;
    err_cnt_d     = err_cnt_q;

    unique case (state_q)
      ST_HUNT: begin
        pipe_vld_d = '0;
        if (bus.capture_en && sync_match) begin
          // The 7 just seen closes the sync, so the next nibble is a low one.
          state_d = ST_SYNCED;
          phase_d = 1'b0;
          idx_d   = '0;
        end
      end

      ST_SYNCED: begin
        if (!bus.capture_en) begin
          state_d    = ST_HUNT;
          pipe_vld_d = '0;
        end else if (!phase_q) begin
          phase_d = 1'b1;
          low_d   = nib_q;
          if (sync_match) begin
            // Sync ended on a low-nibble slot: our phase was wrong. Drop
            // everything in flight and realign on the sync just seen.
            sync_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
              err_cnt_d = err_cnt_q + 8'd1;
            end
            pipe_vld_d = '0;
            phase_d    = 1'b0;
            idx_d      = '0;
          end
        end else begin
          // High nibble: a byte completes and the pipeline advances.
          phase_d = 1'b0;
          if (pipe_vld_q[PIPE_DEPTH-1]) begin
            byte_valid_d  = 1'b1;
            byte_out_d    = pipe_data_q[PIPE_DEPTH-1];
            frame_start_d = (idx_q == '0);
            idx_d         = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          end
          pipe_data_d = {pipe_data_q[PIPE_DEPTH-2:0], {nib_q, low_q}};
          pipe_vld_d  = {pipe_vld_q[PIPE_DEPTH-2:0], 1'b1};
          if (sync_match) begin
            // Aligned sync: the completing 7F and the three FF bytes behind
            // it all vanish; the byte leaving stage 3 is real data and is
            // still emitted above. The next emitted byte starts a frame.
            pipe_vld_d = '0;
            idx_d      = '0;
          end
        end
      end

      default: begin
        state_d    = ST_HUNT;
        pipe_vld_d = '0;
      end
    endcase
  end

  assign bus.byte_out       = byte_out_q;
  assign bus.byte_valid     = byte_valid_q;
  assign bus.frame_start    = frame_start_q;
  assign bus.synced         = (state_q == ST_SYNCED);
  assign bus.sync_err       = sync_err_q;
  assign bus.sync_err_count = err_cnt_q;

endmodule
`default_nettype wire

// File: doc/trace_nibble_framer.md
# trace_nibble_framer

Capture-side front end for the 4-bit parallel trace port. It samples `trace_data` on every `target_clk` edge and hunts for the TPIU full-sync pattern to fix nibble/byte alignment. Once aligned, it assembles bytes, strips full-sync packets and emits a byte stream with frame-boundary markers to the downstream trace buffer. It sits directly after the trace pins, which the trace generator drives in simulation, and ahead of the capture FIFO.

## Interface
- `pFRAME_BYTES`, default 16: bytes per TPIU frame; must be a power of 2, max 256.
- `target_clk`  in  1: trace port clock; all logic is on its rising edge.
- `reset`  in  1: reset, asynchronous, active-low.
- `trace_data`  in  4: trace nibble. The low nibble of each byte comes first.
- `capture_en`  in  1: level enable. Low forces HUNT.
- `byte_out`  out  8: assembled byte.
- `byte_valid`  out  1: single-cycle strobe qualifying `byte_out`.
- `frame_start`  out  1: with `byte_valid`, marks frame byte index 0.
- `synced`  out  1: high in SYNCED state.
- `sync_err`  out  1: single-cycle pulse on a misaligned full sync while SYNCED.
- `sync_err_count`  out  8: saturating count of `sync_err` pulses.

## Operation
- Input register `nib_r` is updated every cycle. A 32-bit nibble history `sr` shifts right with `nib_r` entering `[31:28]`.
- Full sync match: `{nib_r, sr[31:4]} == 32'h7FFF_FFFF`, i.e. nibbles F,F,F,F,F,F,F,7 in arrival order (bytes FF FF FF 7F).
- FSM states are HUNT and SYNCED.
- HUNT → SYNCED on a match while `capture_en`=1. On that transition: `phase` = 0 (next nibble is a low nibble), frame index = 0, byte pipeline flushed.
- In SYNCED, `phase` toggles each cycle. A byte is completed when `phase`=1, as `{nib_r, low_nibble_held}`.
- Byte pipeline: 4 stages with a valid bit each. It shifts only on byte completion. The stage-3 entry, if valid, goes to the output register.
- Aligned match in SYNCED (match on the high-nibble cycle):
  - Mark the completing byte and stages 0-2 invalid, so all 4 sync bytes are squashed.
  - Reset the frame index to 0.
  - Do not pulse `sync_err`.
- Misaligned match in SYNCED (match on the low-nibble cycle):
  - Pulse `sync_err` and increment `sync_err_count`, saturating at 255.
  - Flush all pipeline stages.
  - Set `phase` = 0 for the next nibble and reset the frame index to 0.
- Frame index counts emitted bytes modulo `pFRAME_BYTES`. `frame_start` is asserted with the emitted byte whose index is 0.
- `capture_en` = 0: enter HUNT the next cycle. Flush the pipeline, clear `synced`, hold the counter. The history `sr` keeps shifting.
- Back-to-back syncs are each squashed, and no data is emitted between them.
- Halfword syncs (FF 7F) are not stripped; they pass through as data.

## Timing
- Reset values:
  - All outputs 0 and `sync_err_count` = 0.
  - FSM = HUNT, pipeline invalid, `sr` = 0.
  - Reset is asynchronous and may be asserted mid-frame; it discards all state.
- Latency: for a byte whose high nibble is sampled into `nib_r` at edge E0, `byte_valid`/`byte_out` register at edge E9 (9 cycles). The rate is 1 byte per 2 cycles.
- `byte_valid` is never high on two consecutive cycles. `frame_start` = 0 whenever `byte_valid` = 0.
- `synced` rises at the edge after the match edge. It falls at the edge after `capture_en` is sampled low.
- `sync_err` is high for exactly one cycle, at the edge after the misaligned-match edge. `sync_err_count` updates on the same edge.
- No backpressure: the downstream stage must accept every `byte_valid`.

## Test plan
- Reset check: hold `reset` low with random `trace_data` → all outputs 0. After release with no sync, `byte_valid` stays 0 for 100 cycles.
- Initial sync and frame markers:
  - Stimulus: 20 idle nibbles of 0, the sync nibbles, then bytes 0x00..0x1F.
  - Expected: `synced` = 1; exactly 32 `byte_valid` with values 0x00..0x1F in order; `frame_start` on 0x00 and 0x10; latency 9 cycles; no 0xFF/0x7F sync bytes emitted.
- Aligned resync: after data bytes 0x00..0x05, insert a full sync, then 0xA0..0xAF.
  - Expected: 0x00..0x05 then 0xA0..0xAF; `frame_start` on 0xA0; `sync_err` never asserted.
- Misaligned sync: while SYNCED, insert one extra nibble 0x3, then a full sync, then 0x55,0x66.
  - Expected: one `sync_err` pulse; `sync_err_count` = 1; next emitted bytes are 0x55 (with `frame_start`) then 0x66.
- Enable and reset abort: deassert `capture_en` mid-frame → `synced` drops the next cycle and no further `byte_valid`. Re-enabling without a sync gives no output. Asserting `reset` mid-frame clears everything immediately.
- Saturation: 300 misaligned syncs → `sync_err_count` stops at 255, and data after the final sync is still emitted correctly.
